decoder_2to4: RTL and testbench

DECODER_2TO4 -- requirements
Module: decoder_2to4

---
 rtl/decoder_2to4.sv | 41 ++++
 tb/tb_decoder_2to4.sv | 113 +++++++++++
 2 files changed

// File: rtl/decoder_2to4.sv
// decoder_2to4: registered 2-to-4 one-hot decoder; optional saturating hit counters under DECODER_2TO4_HIT_CNT_EN
module decoder_2to4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             en,
`ifdef DECODER_2TO4_HIT_CNT_EN
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
`endif
  output logic [0:3]       z,
  output logic             valid
);
  logic [0:3] dec;
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("CNT_W out of range 2..16");
  end
  always_comb dec = en ? (4'b1000 >> {a, b}) : 4'b0000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      z     <= 4'b0000;
      valid <= 1'b0;
    end else begin
      z     <= dec;
      valid <= en;
    end
`ifdef DECODER_2TO4_HIT_CNT_EN
  logic [CNT_W-1:0] cnt [4];
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt[k] <= '0;
      else if (cnt_clr) cnt[k] <= '0;
      else if (dec[k] && cnt[k] != '1) cnt[k] <= cnt[k] + CNT_W'(1);
  end
  always_comb cnt_out = cnt[cnt_sel];
`endif
endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: directed checks of decode, reset and (when DECODER_2TO4_HIT_CNT_EN) hit counters
module tb_decoder_2to4;
  logic clk = 1'b0;
  logic rst_n, a, b, en;
  logic [0:3] z;
  logic valid;
  logic cnt_clr;
  logic [1:0] cnt_sel;
  logic [1:0] cnt_out;
  int checks = 0;
  int failures = 0;
  logic [3:0] exp_z [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  always #5 clk = ~clk;
  decoder_2to4 #(.CNT_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .en(en),
`ifdef DECODER_2TO4_HIT_CNT_EN
    .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel),
    .cnt_out(cnt_out),
`endif
    .z(z),
    .valid(valid)
  );
`ifndef DECODER_2TO4_HIT_CNT_EN
  assign cnt_out = 2'b00;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b1; a = 1'b0; b = 1'b0; en = 1'b0; cnt_clr = 1'b0; cnt_sel = 2'd0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_z", z, 4'b0000);
    check("rst_valid", valid, 1'b0);
    en = 1'b1; a = 1'b1; b = 1'b1;
    repeat (2) edge_wait();
    check("rst_hold_z", z, 4'b0000);
    check("rst_hold_valid", valid, 1'b0);
    rst_n = 1'b1; en = 1'b0; a = 1'b0; b = 1'b1;
    edge_wait();
    check("dis_z", z, 4'b0000);
    check("dis_valid", valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = i[1]; b = i[0]; en = 1'b1;
      edge_wait();
      check($sformatf("dec%0d_z", i), z, exp_z[i]);
      check($sformatf("dec%0d_valid", i), valid, 1'b1);
    end
    en = 1'b0; a = 1'b1; b = 1'b0;
    edge_wait();
    check("en0_z", z, 4'b0000);
    check("en0_valid", valid, 1'b0);
    en = 1'b1; a = 1'b1; b = 1'b1;
    edge_wait();
    check("pre_mid_rst_z", z, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_z", z, 4'b0000);
    check("mid_rst_valid", valid, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    check("post_rel_z", z, 4'b0000);
    check("post_rel_valid", valid, 1'b0);
    en = 1'b0;
    edge_wait();
    check("discard_z", z, 4'b0000);
    check("discard_valid", valid, 1'b0);
    en = 1'b1; a = 1'b0; b = 1'b0;
    edge_wait();
    check("first_dec_z", z, 4'b1000);
`ifdef DECODER_2TO4_HIT_CNT_EN
    cnt_clr = 1'b1; en = 1'b0;
    edge_wait();
    cnt_clr = 1'b0; cnt_sel = 2'd2;
    #1 check("cnt_cleared", cnt_out, 2'd0);
    en = 1'b1; a = 1'b1; b = 1'b0;
    repeat (2) edge_wait();
    check("cnt2_two", cnt_out, 2'd2);
    repeat (3) edge_wait();
    check("cnt2_sat", cnt_out, 2'd3);
    cnt_sel = 2'd0;
    #1 check("cnt0_zero", cnt_out, 2'd0);
    a = 1'b0; b = 1'b1; cnt_clr = 1'b1;
    edge_wait();
    cnt_sel = 2'd1;
    #1 check("clr_wins", cnt_out, 2'd0);
    cnt_clr = 1'b0;
    edge_wait();
    check("cnt1_one", cnt_out, 2'd1);
    cnt_sel = 2'd2;
    #1 check("cnt2_after_clr", cnt_out, 2'd0);
    cnt_sel = 2'd1;
    rst_n = 1'b0;
    #1 check("cnt_rst", cnt_out, 2'd0);
    rst_n = 1'b1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
